uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_os_tick.sv | 30 +++
 rtl/uart_rx_os.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the oversampling UART receiver:
//   - rx_state_t   : receiver FSM state encoding
//   - P_NONE/P_ODD/P_EVE : parity type constants for PARITY_TYPE
//   - par_err_calc : parity error decision from XOR(data, parity bit)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  localparam int P_NONE = 0;
  localparam int P_ODD  = 1;
  localparam int P_EVE  = 2;

  // x is the XOR of all data bits and the received parity bit.
  function automatic logic par_err_calc(input int ptype, input logic x);
    logic err;
    err = 1'b0;
    if (ptype == P_ODD)      err = ~x;
    else if (ptype == P_EVE) err = x;
    return err;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick
//   Free-running oversample tick generator: oTick pulses for one cycle
//   every DIV clock cycles, starting from reset.
//   Ports: iClk (clock), iRst (async active-low reset), oTick (tick pulse).
module uart_os_tick #(
  parameter int DIV = 325
) (
  input  logic iClk,
  input  logic iRst,
  output logic oTick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign oTick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os
//   Oversampling UART receiver with receive buffer.
//   Ports:
//     iClk, iRst (async active-low)       : clock / reset
//     iRx                                 : serial line, idle high
//     iData_ready                         : consumer accepts head word
//     oData_rx, oPar_err, oFrm_err        : head word and its error flags
//     oData_valid                         : buffer not empty
//     oOvr_err, oBreak                    : one-cycle event pulses
//     oFifo_count                         : words held
//   Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO;
//   otherwise a single holding register is used.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OS_RATE     = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iRx,
  input  logic                        iData_ready,
  output logic [DATA_BITS-1:0]        oData_rx,
  output logic                        oData_valid,
  output logic                        oPar_err,
  output logic                        oFrm_err,
  output logic                        oOvr_err,
  output logic                        oBreak,
  output logic [$clog2(FIFO_DEPTH):0] oFifo_count
);

  localparam int DIV    = CLK_FREQ / (BAUD_RATE * OS_RATE);
  localparam int TC_W   = $clog2(OS_RATE) + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = DATA_BITS + 2;
`ifdef UART_RX_FIFO_EN
  localparam int EFF_DEPTH = FIFO_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif

  localparam logic [TC_W-1:0]  TC_ONE  = TC_W'(1);
  localparam logic [TC_W-1:0]  TC_HALF = TC_W'(OS_RATE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_BIT  = TC_W'(OS_RATE - 1);
  localparam logic [3:0]       BC_ONE  = 4'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic tick;
  logic rx_meta_q, rx_sync_q;

  rx_state_t            state_q, state_d;
  logic [TC_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 frm_err_q, frm_err_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;

  logic              push, pop, full, push_ok;
  logic [WORD_W-1:0] push_word, head;
  logic [CNT_W-1:0]  count_q, count_d;

  uart_os_tick #(.DIV(DIV)) u_tick (
    .iClk  (iClk),
    .iRst  (iRst),
    .oTick (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= iRx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver FSM next state. All timing advances only on oversample ticks;
  // tick_cnt counts ticks within the current bit so samples land mid-bit.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    frm_err_d  = frm_err_q;
    brk_d      = 1'b0;
    push       = 1'b0;
    push_word  = {par_err_calc(PARITY_TYPE, (^shift_q) ^ par_bit_q),
                  frm_err_q | ~rx_sync_q, shift_q};
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_sync_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            frm_err_d  = 1'b0;
            par_bit_d  = 1'b0;
          end
        end
        ST_START: begin
          if (tick_cnt_q == TC_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TC_ONE;
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == TC_BIT) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_TYPE != P_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BC_ONE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TC_ONE;
          end
        end
        ST_PARITY: begin
          if (tick_cnt_q == TC_BIT) begin
            tick_cnt_d = '0;
            par_bit_d  = rx_sync_q;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TC_ONE;
          end
        end
        ST_STOP: begin
          if (tick_cnt_q == TC_BIT) begin
            tick_cnt_d = '0;
            // par_bit_q is cleared at frame start, so it reads 0 without parity.
            if ((bit_cnt_q == '0) && (shift_q == '0) && !par_bit_q && !rx_sync_q) begin
              brk_d   = 1'b1;
              state_d = ST_BRK_WAIT;
            end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + BC_ONE;
              frm_err_d = frm_err_q | ~rx_sync_q;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TC_ONE;
          end
        end
        ST_BRK_WAIT: begin
          // Any low sample restarts the required run of high ticks.
          if (!rx_sync_q) begin
            tick_cnt_d = '0;
          end else if (tick_cnt_q == TC_BIT) begin
            tick_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TC_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      frm_err_q  <= frm_err_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
      count_q    <= count_d;
    end
  end

  // Buffer control. A pop in the same cycle frees the slot a full buffer
  // needs, so push-with-pop when full is accepted.
  assign pop     = (count_q != '0) && iData_ready;
  assign full    = (count_q == CNT_W'(EFF_DEPTH));
  assign push_ok = push && (!full || pop);
  assign ovr_d   = push && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop) count_d = count_q - CNT_ONE;
  end

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign head = mem_q[rd_ptr_q];
`else
  logic [WORD_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = push_ok ? push_word : hold_q;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign head = hold_q;
`endif

  // Head fields are masked while empty so stale storage never shows.
  assign oData_valid = (count_q != '0);
  assign oData_rx    = oData_valid ? head[DATA_BITS-1:0] : '0;
  assign oFrm_err    = oData_valid & head[DATA_BITS];
  assign oPar_err    = oData_valid & head[DATA_BITS+1];
  assign oOvr_err    = ovr_q;
  assign oBreak      = brk_q;
  assign oFifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: three receivers (8N1, 8E1, 8N2) on separate
// lines. The clock frequency is scaled so one bit lasts 64 clocks (DIV=4).
module tb_uart_rx_os;

   localparam int CLK_FREQ = 614400;
   localparam int BAUD     = 9600;
   localparam int OS       = 16;
   localparam int BIT_CYC  = (CLK_FREQ / (BAUD * OS)) * OS;
`ifdef UART_RX_FIFO_EN
   localparam int EFF_DEPTH = 8;
`else
   localparam int EFF_DEPTH = 1;
`endif

   logic clock = 1'b0;
   logic reset;
   logic rxLine   [3];
   logic readyIn  [3];
   logic [7:0] dataOut [3];
   logic validOut [3];
   logic parOut   [3];
   logic frmOut   [3];
   logic ovrOut   [3];
   logic brkOut   [3];
   logic [3:0] countOut [3];

   int assertCount = 0;
   int failCount   = 0;
   int validCycles [3] = '{0, 0, 0};
   int ovrCount    [3] = '{0, 0, 0};
   int brkCount    [3] = '{0, 0, 0};
   logic [7:0] lastData [3] = '{8'h00, 8'h00, 8'h00};
   logic lastPar [3] = '{1'b0, 1'b0, 1'b0};
   logic lastFrm [3] = '{1'b0, 1'b0, 1'b0};

   // 10 ns clock
   always #5 clock = ~clock;

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OS_RATE(OS), .DATA_BITS(8),
                .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(8)) dut8n1 (
      .iClk(clock), .iRst(~reset), .iRx(rxLine[0]), .iData_ready(readyIn[0]),
      .oData_rx(dataOut[0]), .oData_valid(validOut[0]), .oPar_err(parOut[0]),
      .oFrm_err(frmOut[0]), .oOvr_err(ovrOut[0]), .oBreak(brkOut[0]),
      .oFifo_count(countOut[0]));

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OS_RATE(OS), .DATA_BITS(8),
                .PARITY_TYPE(2), .STOP_BITS(1), .FIFO_DEPTH(8)) dut8e1 (
      .iClk(clock), .iRst(~reset), .iRx(rxLine[1]), .iData_ready(readyIn[1]),
      .oData_rx(dataOut[1]), .oData_valid(validOut[1]), .oPar_err(parOut[1]),
      .oFrm_err(frmOut[1]), .oOvr_err(ovrOut[1]), .oBreak(brkOut[1]),
      .oFifo_count(countOut[1]));

   uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OS_RATE(OS), .DATA_BITS(8),
                .PARITY_TYPE(0), .STOP_BITS(2), .FIFO_DEPTH(8)) dut8n2 (
      .iClk(clock), .iRst(~reset), .iRx(rxLine[2]), .iData_ready(readyIn[2]),
      .oData_rx(dataOut[2]), .oData_valid(validOut[2]), .oPar_err(parOut[2]),
      .oFrm_err(frmOut[2]), .oOvr_err(ovrOut[2]), .oBreak(brkOut[2]),
      .oFifo_count(countOut[2]));

   // Observe outputs on the falling edge: count valid cycles and event
   // pulses, and remember the last word presented by each receiver.
   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (validOut[i]) begin
            validCycles[i] <= validCycles[i] + 1;
            lastData[i]    <= dataOut[i];
            lastPar[i]     <= parOut[i];
            lastFrm[i]     <= frmOut[i];
         end
         if (ovrOut[i]) ovrCount[i] <= ovrCount[i] + 1;
         if (brkOut[i]) brkCount[i] <= brkCount[i] + 1;
      end
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Shift nBits of a pattern LSB first onto one line, then idle two bits.
   task automatic applyStimulus(input int line, input logic [15:0] bits, input int nBits);
      for (int b = 0; b < nBits; b++) begin
         rxLine[line] = bits[b];
         repeat (BIT_CYC) @(posedge clock);
      end
      rxLine[line] = 1'b1;
      repeat (2 * BIT_CYC) @(posedge clock);
   endtask

   // Standard 8N1 frame on line 0.
   task automatic sendByte0(input logic [7:0] value);
      applyStimulus(0, {7'h00, 1'b1, value, 1'b0}, 10);
   endtask

   initial begin
      int v0, b0, o0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rxLine[i]  = 1'b1;
         readyIn[i] = 1'b1;
      end
      repeat (5) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_valid", validOut[0], 1'b0);
      checkOutput("rst_data",  dataOut[0],  8'h00);
      checkOutput("rst_par",   parOut[0],   1'b0);
      checkOutput("rst_frm",   frmOut[0],   1'b0);
      checkOutput("rst_ovr",   ovrOut[0],   1'b0);
      checkOutput("rst_brk",   brkOut[0],   1'b0);
      checkOutput("rst_count", countOut[0], 4'd0);
      reset = 1'b0;
      repeat (BIT_CYC) @(posedge clock);

      // 8N1 0xA5
      v0 = validCycles[0];
      sendByte0(8'hA5);
      checkOutput("8n1_validcyc", validCycles[0] - v0, 1);
      checkOutput("8n1_data", lastData[0], 8'hA5);
      checkOutput("8n1_par",  lastPar[0], 1'b0);
      checkOutput("8n1_frm",  lastFrm[0], 1'b0);

      // 8E1 0x07 with parity bit 0 (three ones -> even parity bit must be 1)
      applyStimulus(1, {5'h00, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
      checkOutput("8e1_data", lastData[1], 8'h07);
      checkOutput("8e1_parerr", lastPar[1], 1'b1);
      checkOutput("8e1_frm", lastFrm[1], 1'b0);
      // 8E1 0x03 with parity bit 0 is correct
      applyStimulus(1, {5'h00, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
      checkOutput("8e1_ok_data", lastData[1], 8'h03);
      checkOutput("8e1_ok_par", lastPar[1], 1'b0);

      // 8N2 0x3C with second stop bit low
      applyStimulus(2, {5'h00, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
      checkOutput("8n2_data", lastData[2], 8'h3C);
      checkOutput("8n2_frmerr", lastFrm[2], 1'b1);
      checkOutput("8n2_par", lastPar[2], 1'b0);

      // Overrun: consumer stalled, one more frame than the buffer holds
      readyIn[0] = 1'b0;
      o0 = ovrCount[0];
      for (int k = 1; k <= EFF_DEPTH + 1; k++) sendByte0(8'(k));
      @(negedge clock);
      checkOutput("ovr_count", countOut[0], 4'(EFF_DEPTH));
      checkOutput("ovr_pulses", ovrCount[0] - o0, 1);
      for (int k = 1; k <= EFF_DEPTH; k++) begin
         @(negedge clock);
         checkOutput($sformatf("pop%0d", k), dataOut[0], 8'(k));
         readyIn[0] = 1'b1;
         @(negedge clock);
         readyIn[0] = 1'b0;
      end
      checkOutput("drained", countOut[0], 4'd0);
      readyIn[0] = 1'b1;

      // Break: 12 bit times low, then a normal frame
      v0 = validCycles[0];
      b0 = brkCount[0];
      applyStimulus(0, 16'h0000, 12);
      checkOutput("brk_pulses", brkCount[0] - b0, 1);
      checkOutput("brk_nopush", validCycles[0] - v0, 0);
      sendByte0(8'h55);
      checkOutput("after_brk_validcyc", validCycles[0] - v0, 1);
      checkOutput("after_brk_data", lastData[0], 8'h55);

      // Glitch of 4 ticks on idle line
      v0 = validCycles[0];
      rxLine[0] = 1'b0;
      repeat (BIT_CYC / 4) @(posedge clock);
      rxLine[0] = 1'b1;
      repeat (2 * BIT_CYC) @(posedge clock);
      checkOutput("glitch_nopush", validCycles[0] - v0, 0);
      sendByte0(8'h81);
      checkOutput("after_glitch_data", lastData[0], 8'h81);
      checkOutput("after_glitch_validcyc", validCycles[0] - v0, 1);

      // Reset in the middle of the data bits with a word held
      readyIn[0] = 1'b0;
      sendByte0(8'h42);
      @(negedge clock);
      checkOutput("held_count", countOut[0], 4'd1);
      rxLine[0] = 1'b0;
      repeat (3 * BIT_CYC) @(posedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("midrst_valid", validOut[0], 1'b0);
      checkOutput("midrst_data",  dataOut[0],  8'h00);
      checkOutput("midrst_count", countOut[0], 4'd0);
      checkOutput("midrst_par",   parOut[0],   1'b0);
      checkOutput("midrst_frm",   frmOut[0],   1'b0);
      checkOutput("midrst_ovr",   ovrOut[0],   1'b0);
      checkOutput("midrst_brk",   brkOut[0],   1'b0);
      rxLine[0]  = 1'b1;
      readyIn[0] = 1'b1;
      reset      = 1'b0;
      repeat (BIT_CYC) @(posedge clock);
      sendByte0(8'h99);
      checkOutput("post_rst_data", lastData[0], 8'h99);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
